next_pc_unit: RTL and testbench

NEXT_PC_UNIT -- requirements
Module: next_pc_unit

---
 rtl/npc_pkg.sv | 6 +
 rtl/next_pc_unit_if.sv | 29 ++
 rtl/npc_ras.sv | 32 +++
 rtl/next_pc_unit.sv | 77 +++++++
 tb/tb_next_pc_unit.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/npc_pkg.sv
// npc_pkg: shared constants and FSM encoding for the next-PC unit
package npc_pkg;
  localparam int ADDR_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_3000;
  typedef enum logic {SEQ = 1'b0, PEND = 1'b1} npc_state_e;
endpackage

// File: rtl/next_pc_unit_if.sv
// next_pc_unit_if: control inputs and PC outputs of the next-PC unit
interface next_pc_unit_if #(parameter int RAS_DEPTH = 4);
  import npc_pkg::*;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic en;
  logic redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic br_taken;
  logic [15:0] br_imm;
  logic jump;
  logic [25:0] jump_index;
  logic link;
  logic jr;
  logic [ADDR_W-1:0] jr_target;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic [ADDR_W-1:0] link_addr;
  logic pending;
  logic ras_mispredict;
  logic [CW-1:0] ras_count;
  modport master (
    output en, redirect, redirect_pc, br_taken, br_imm, jump, jump_index, link, jr, jr_target,
    input pc, pc_plus4, link_addr, pending, ras_mispredict, ras_count
  );
  modport slave (
    input en, redirect, redirect_pc, br_taken, br_imm, jump, jump_index, link, jr, jr_target,
    output pc, pc_plus4, link_addr, pending, ras_mispredict, ras_count
  );
endinterface

// File: rtl/npc_ras.sv
// npc_ras: circular return-address stack; a push when full overwrites the oldest entry
module npc_ras import npc_pkg::*; #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [CW-1:0]     count
);
  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0] ptr;
  assign top = mem[ptr - PW'(1)];
  // ptr is the next write slot; wrapping onto the oldest entry gives the overwrite
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      count <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr <= ptr + PW'(1);
      count <= (count == CW'(DEPTH)) ? count : count + CW'(1);
    end else if (pop && count != '0) begin
      ptr <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end
endmodule

// File: rtl/next_pc_unit.sv
// next_pc_unit: fetch PC sequencing with optional delay slot and return-address prediction
module next_pc_unit import npc_pkg::*; #(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int DELAY_SLOT = 0,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1)
) (
  input logic clk,
  input logic reset,
  next_pc_unit_if.slave bus
);
  npc_state_e state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, lat, lat_d, pc_plus4, link_addr, br_tgt, j_tgt, tgt, ras_top;
  logic [CW-1:0] ras_count;
  logic ctrl, accept, acc_jr, acc_push, mp;
  assign pc_plus4 = pc + 32'd4;
  assign link_addr = pc + ((DELAY_SLOT != 0) ? 32'd8 : 32'd4);
  assign br_tgt = pc_plus4 + {{14{bus.br_imm[15]}}, bus.br_imm, 2'b00};
  assign j_tgt = {pc_plus4[31:28], bus.jump_index, 2'b00};
  assign tgt = bus.jr ? bus.jr_target : bus.jump ? j_tgt : br_tgt;
  assign ctrl = bus.jr | bus.jump | bus.br_taken;
  assign accept = bus.en & ~bus.redirect & (state == SEQ);
  assign acc_jr = accept & bus.jr;
  assign acc_push = accept & ~bus.jr & bus.jump & bus.link;
  // next PC and delay-slot state; redirect wins and drops any latched target
  always_comb begin
    state_d = state;
    pc_d = pc;
    lat_d = lat;
    if (bus.en) begin
      if (bus.redirect) begin
        pc_d = bus.redirect_pc;
        state_d = SEQ;
        lat_d = '0;
      end else if (state == PEND) begin
        pc_d = lat;
        state_d = SEQ;
        lat_d = '0;
      end else if (DELAY_SLOT != 0 && ctrl) begin
        pc_d = pc_plus4;
        lat_d = tgt;
        state_d = PEND;
      end else begin
        pc_d = ctrl ? tgt : pc_plus4;
      end
    end
  end
  // state registers and one-cycle mispredict flag for accepted jr
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEQ;
      pc <= RESET_PC;
      lat <= '0;
      mp <= 1'b0;
    end else begin
      state <= state_d;
      pc <= pc_d;
      lat <= lat_d;
      mp <= acc_jr & (ras_count == '0 || ras_top != bus.jr_target);
    end
  end
  npc_ras #(.DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .reset(reset),
    .push(acc_push),
    .pop(acc_jr),
    .push_data(link_addr),
    .top(ras_top),
    .count(ras_count)
  );
  assign bus.pc = pc;
  assign bus.pc_plus4 = pc_plus4;
  assign bus.link_addr = link_addr;
  assign bus.pending = (state == PEND);
  assign bus.ras_mispredict = mp;
  assign bus.ras_count = ras_count;
endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed and randomized checks of next_pc_unit, immediate and delay-slot variants
module tb_next_pc_unit;
  logic clk = 0, reset = 1;
  always #5 clk = ~clk;
  logic en = 0, redirect = 0, br_taken = 0, jump = 0, link = 0, jr = 0;
  logic [31:0] redirect_pc = 0, jr_target = 0;
  logic [15:0] br_imm = 0;
  logic [25:0] jump_index = 0;
  next_pc_unit_if #(.RAS_DEPTH(4)) b0 ();
  next_pc_unit_if #(.RAS_DEPTH(4)) b1 ();
  assign {b0.en, b0.redirect, b0.redirect_pc, b0.br_taken, b0.br_imm, b0.jump, b0.jump_index, b0.link, b0.jr, b0.jr_target} =
         {en, redirect, redirect_pc, br_taken, br_imm, jump, jump_index, link, jr, jr_target};
  assign {b1.en, b1.redirect, b1.redirect_pc, b1.br_taken, b1.br_imm, b1.jump, b1.jump_index, b1.link, b1.jr, b1.jr_target} =
         {en, redirect, redirect_pc, br_taken, br_imm, jump, jump_index, link, jr, jr_target};
  next_pc_unit #(.DELAY_SLOT(0), .RAS_DEPTH(4)) d0 (.clk(clk), .reset(reset), .bus(b0.slave));
  next_pc_unit #(.DELAY_SLOT(1), .RAS_DEPTH(4)) d1 (.clk(clk), .reset(reset), .bus(b1.slave));
  logic [31:0] o_pc [2], o_p4 [2], o_la [2];
  logic o_pend [2], o_mp [2];
  logic [2:0] o_cnt [2];
  assign o_pc[0] = b0.pc;
  assign o_pc[1] = b1.pc;
  assign o_p4[0] = b0.pc_plus4;
  assign o_p4[1] = b1.pc_plus4;
  assign o_la[0] = b0.link_addr;
  assign o_la[1] = b1.link_addr;
  assign o_pend[0] = b0.pending;
  assign o_pend[1] = b1.pending;
  assign o_mp[0] = b0.ras_mispredict;
  assign o_mp[1] = b1.ras_mispredict;
  assign o_cnt[0] = b0.ras_count;
  assign o_cnt[1] = b1.ras_count;
  int n_checks = 0, n_fail = 0;
  logic [31:0] m_pc [2], m_tgt [2];
  logic m_pend [2], m_mp [2];
  logic [31:0] m_ras [2][$];

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [31:0] pp4, t;
      if (reset) begin
        m_pc[k] = 32'h3000; m_pend[k] = 0; m_tgt[k] = 0; m_mp[k] = 0; m_ras[k].delete();
        continue;
      end
      m_mp[k] = 0;
      if (!en) continue;
      if (redirect) begin m_pc[k] = redirect_pc; m_pend[k] = 0; continue; end
      if (m_pend[k]) begin m_pc[k] = m_tgt[k]; m_pend[k] = 0; continue; end
      pp4 = m_pc[k] + 32'd4;
      t = jr ? jr_target : jump ? {pp4[31:28], jump_index, 2'b00} : pp4 + 32'(4 * int'($signed(br_imm)));
      if (jr) begin
        m_mp[k] = m_ras[k].size() == 0 || m_ras[k][$] != jr_target;
        if (m_ras[k].size() != 0) void'(m_ras[k].pop_back());
      end else if (jump && link) begin
        m_ras[k].push_back(m_pc[k] + 32'(k == 1 ? 8 : 4));
        if (m_ras[k].size() > 4) void'(m_ras[k].pop_front());
      end
      if (!(jr || jump || br_taken)) m_pc[k] = pp4;
      else if (k == 1) begin m_pend[k] = 1; m_tgt[k] = t; m_pc[k] = pp4; end
      else m_pc[k] = t;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    en = 0; redirect = 0; br_taken = 0; jump = 0; link = 0; jr = 0;
    redirect_pc = 0; jr_target = 0; br_imm = 0; jump_index = 0;
  endtask

  task automatic do_reset();
    clear_in();
    reset = 1;
    step();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; en = 1; jump = 1; link = 1; jr = 1; br_taken = 1;
    step();
    for (int k = 0; k < 2; k++) begin
      n_checks += 4;
      if (o_pc[k] !== 32'h3000) begin n_fail++; $display("FAIL reset_pc[%0d] got %h want %h", k, o_pc[k], 32'h3000); end
      if (o_pend[k] !== 1'b0) begin n_fail++; $display("FAIL reset_pending[%0d] got %b want 0", k, o_pend[k]); end
      if (o_cnt[k] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d] got %0d want 0", k, o_cnt[k]); end
      if (o_mp[k] !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict[%0d] got %b want 0", k, o_mp[k]); end
    end
    reset = 0;
    clear_in();
  endtask

  task automatic test_sequential();
    do_reset();
    en = 1;
    for (int i = 1; i <= 3; i++) begin
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (o_pc[k] !== 32'h3000 + 32'(4 * i)) begin
          n_fail++; $display("FAIL seq_pc[%0d] cycle %0d got %h want %h", k, i, o_pc[k], 32'h3000 + 32'(4 * i));
        end
      end
    end
  endtask

  task automatic test_branch_back();
    do_reset();
    en = 1; br_taken = 1; br_imm = 16'hFFFF;
    step();
    n_checks += 3;
    if (o_pc[0] !== 32'h3000) begin n_fail++; $display("FAIL br_back_pc0 got %h want %h", o_pc[0], 32'h3000); end
    if (o_pc[1] !== 32'h3004) begin n_fail++; $display("FAIL br_slot_pc1 got %h want %h", o_pc[1], 32'h3004); end
    if (o_pend[1] !== 1'b1) begin n_fail++; $display("FAIL br_slot_pending got %b want 1", o_pend[1]); end
    br_taken = 0;
    step();
    n_checks += 3;
    if (o_pc[1] !== 32'h3000) begin n_fail++; $display("FAIL br_tgt_pc1 got %h want %h", o_pc[1], 32'h3000); end
    if (o_pend[1] !== 1'b0) begin n_fail++; $display("FAIL br_tgt_pending got %b want 0", o_pend[1]); end
    if (o_pc[0] !== 32'h3004) begin n_fail++; $display("FAIL br_next_pc0 got %h want %h", o_pc[0], 32'h3004); end
  endtask

  task automatic test_delay_jump();
    do_reset();
    en = 1; jump = 1; jump_index = 26'h0000C10;
    step();
    n_checks += 3;
    if (o_pc[1] !== 32'h3004) begin n_fail++; $display("FAIL dj_slot_pc got %h want %h", o_pc[1], 32'h3004); end
    if (o_pend[1] !== 1'b1) begin n_fail++; $display("FAIL dj_slot_pending got %b want 1", o_pend[1]); end
    if (o_pc[0] !== 32'h3040) begin n_fail++; $display("FAIL dj_imm_pc0 got %h want %h", o_pc[0], 32'h3040); end
    step();
    n_checks += 2;
    if (o_pc[1] !== 32'h3040) begin n_fail++; $display("FAIL dj_tgt_pc got %h want %h", o_pc[1], 32'h3040); end
    if (o_pend[1] !== 1'b0) begin n_fail++; $display("FAIL dj_tgt_pending got %b want 0", o_pend[1]); end
    jump = 0;
  endtask

  task automatic test_pend_redirect();
    do_reset();
    en = 1; jump = 1; jump_index = 26'h0000C10;
    step();
    jump = 0; redirect = 1; redirect_pc = 32'h4180;
    step();
    n_checks += 2;
    if (o_pc[1] !== 32'h4180) begin n_fail++; $display("FAIL pr_pc got %h want %h", o_pc[1], 32'h4180); end
    if (o_pend[1] !== 1'b0) begin n_fail++; $display("FAIL pr_pending got %b want 0", o_pend[1]); end
    redirect = 0;
    step();
    n_checks++;
    if (o_pc[1] !== 32'h4184) begin n_fail++; $display("FAIL pr_after_pc got %h want %h", o_pc[1], 32'h4184); end
  endtask

  task automatic test_ras_predict();
    do_reset();
    en = 1; jump = 1; link = 1; jump_index = 26'h0000C10;
    step();
    n_checks++;
    if (o_cnt[1] !== 3'd1) begin n_fail++; $display("FAIL rp_push_count got %0d want 1", o_cnt[1]); end
    jump = 0; link = 0;
    step();
    jr = 1; jr_target = 32'h3008;
    step();
    n_checks += 4;
    if (o_mp[1] !== 1'b0) begin n_fail++; $display("FAIL rp_hit_mispredict got %b want 0", o_mp[1]); end
    if (o_cnt[1] !== 3'd0) begin n_fail++; $display("FAIL rp_pop_count got %0d want 0", o_cnt[1]); end
    if (o_pc[1] !== 32'h3044) begin n_fail++; $display("FAIL rp_slot_pc got %h want %h", o_pc[1], 32'h3044); end
    if (o_mp[0] !== m_mp[0]) begin n_fail++; $display("FAIL rp_mispredict0 got %b want %b", o_mp[0], m_mp[0]); end
    jr = 0;
    step();
    n_checks++;
    if (o_pc[1] !== 32'h3008) begin n_fail++; $display("FAIL rp_jr_pc got %h want %h", o_pc[1], 32'h3008); end
    jr = 1;
    step();
    n_checks++;
    if (o_mp[1] !== 1'b1) begin n_fail++; $display("FAIL rp_empty_mispredict got %b want 1", o_mp[1]); end
    jr = 0;
    step();
    n_checks++;
    if (o_mp[1] !== 1'b0) begin n_fail++; $display("FAIL rp_pulse_end got %b want 0", o_mp[1]); end
  endtask

  task automatic test_ras_overflow_stall();
    logic [31:0] pops [5] = '{32'h3074, 32'h3064, 32'h3054, 32'h3044, 32'h3004};
    do_reset();
    en = 1; jump = 1; link = 1;
    for (int i = 0; i < 5; i++) begin
      jump_index = 26'h0000C10 + 26'(4 * i);
      step();
    end
    n_checks += 2;
    if (o_cnt[0] !== 3'd4) begin n_fail++; $display("FAIL ov_count got %0d want 4", o_cnt[0]); end
    if (o_pc[0] !== 32'h3080) begin n_fail++; $display("FAIL ov_pc got %h want %h", o_pc[0], 32'h3080); end
    en = 0;
    step();
    n_checks += 4;
    if (o_pc[0] !== 32'h3080) begin n_fail++; $display("FAIL stall_pc got %h want %h", o_pc[0], 32'h3080); end
    if (o_cnt[0] !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", o_cnt[0]); end
    if (o_pc[1] !== m_pc[1]) begin n_fail++; $display("FAIL stall_pc1 got %h want %h", o_pc[1], m_pc[1]); end
    if (o_cnt[1] !== 3'(m_ras[1].size())) begin n_fail++; $display("FAIL stall_count1 got %0d want %0d", o_cnt[1], m_ras[1].size()); end
    en = 1; jump = 0; link = 0; jr = 1;
    for (int i = 0; i < 5; i++) begin
      jr_target = pops[i];
      step();
      n_checks++;
      if (o_mp[0] !== (i == 4)) begin n_fail++; $display("FAIL ov_pop%0d_mispredict got %b want %b", i, o_mp[0], i == 4); end
    end
    n_checks++;
    if (o_cnt[0] !== 3'd0) begin n_fail++; $display("FAIL ov_final_count got %0d want 0", o_cnt[0]); end
    jr = 0;
  endtask

  task automatic test_reset_mid_pend();
    do_reset();
    en = 1; jump = 1; jump_index = 26'h0000C10;
    step();
    reset = 1;
    step();
    n_checks += 2;
    if (o_pc[1] !== 32'h3000) begin n_fail++; $display("FAIL rmp_pc got %h want %h", o_pc[1], 32'h3000); end
    if (o_pend[1] !== 1'b0) begin n_fail++; $display("FAIL rmp_pending got %b want 0", o_pend[1]); end
    reset = 0;
    clear_in();
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      en = $urandom_range(0, 9) < 8;
      redirect = $urandom_range(0, 19) == 0;
      jr = $urandom_range(0, 7) == 0;
      jump = $urandom_range(0, 4) == 0;
      link = 1'($urandom_range(0, 1));
      br_taken = $urandom_range(0, 3) == 0;
      br_imm = 16'($urandom);
      jump_index = 26'($urandom);
      redirect_pc = $urandom;
      jr_target = $urandom;
      if (m_ras[1].size() != 0 && $urandom_range(0, 1) == 1) jr_target = m_ras[1][$];
      else if (m_ras[0].size() != 0 && $urandom_range(0, 1) == 1) jr_target = m_ras[0][$];
      step();
      for (int k = 0; k < 2; k++) begin
        n_checks += 6;
        if (o_pc[k] !== m_pc[k]) begin n_fail++; $display("FAIL rnd_pc[%0d] n=%0d got %h want %h", k, n, o_pc[k], m_pc[k]); end
        if (o_pend[k] !== m_pend[k]) begin n_fail++; $display("FAIL rnd_pending[%0d] n=%0d got %b want %b", k, n, o_pend[k], m_pend[k]); end
        if (o_cnt[k] !== 3'(m_ras[k].size())) begin n_fail++; $display("FAIL rnd_count[%0d] n=%0d got %0d want %0d", k, n, o_cnt[k], m_ras[k].size()); end
        if (o_mp[k] !== m_mp[k]) begin n_fail++; $display("FAIL rnd_mispredict[%0d] n=%0d got %b want %b", k, n, o_mp[k], m_mp[k]); end
        if (o_p4[k] !== m_pc[k] + 32'd4) begin n_fail++; $display("FAIL rnd_pc_plus4[%0d] n=%0d got %h want %h", k, n, o_p4[k], m_pc[k] + 32'd4); end
        if (o_la[k] !== m_pc[k] + 32'(k == 1 ? 8 : 4)) begin
          n_fail++; $display("FAIL rnd_link_addr[%0d] n=%0d got %h want %h", k, n, o_la[k], m_pc[k] + 32'(k == 1 ? 8 : 4));
        end
      end
    end
    clear_in();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch_back();
    test_delay_jump();
    test_pend_redirect();
    test_ras_predict();
    test_ras_overflow_stall();
    test_reset_mid_pend();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
